byte_unpack_fifo: RTL and testbench
===================================

BYTE_UNPACK_FIFO -- requirements
Module: byte_unpack_fifo

Interface
REQ-001 Parameters SHALL be, one per line:
- ABITS, default 3, byte address width, so depth is 2^ABITS = 8 bytes.
- DBITS, default 2, output symbol width in bits.
- WBITS, default 8, input word width in bits; WBITS/DBITS = 4 symbols per byte.
REQ-002 Ports SHALL be, one per line:
- clk  input  1  single clock; all logic on the rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- write  input  1  write strobe; enqueues din.
- read  input  1  read strobe; consumes one symbol.
- din  input  WBITS  byte to enqueue.
- dout  output  DBITS  current head symbol (first-word-fall-through).
- empty  output  1  no symbols available.
- full  output  1  no byte slot free.
REQ-003 The block SHALL use one clock, clk; reset_n SHALL be asynchronous and active-low.

Function
REQ-004 Storage SHALL be 2^ABITS bytes, addressed by ABITS-bit write and read pointers that wrap modulo 2^ABITS.
REQ-005 A byte-occupancy counter of ABITS+1 bits SHALL track stored bytes, range 0..2^ABITS.
REQ-006 A symbol index sub of log2(WBITS/DBITS) = 2 bits SHALL select the current symbol within the head byte.
REQ-007 Symbols SHALL be emitted LSB-first: index 0 is din[1:0], index 3 is din[7:6].
REQ-008 dout SHALL equal mem[rd_ptr][sub*DBITS +: DBITS] combinationally whenever empty=0, and 0 when empty=1.
REQ-009 A write with full=0 SHALL store din at wr_ptr, increment wr_ptr, and increment the counter.
REQ-010 A write with full=1 SHALL be ignored, even if a pop occurs in the same cycle.
REQ-011 A read with empty=0 and sub<3 SHALL increment sub; pointers and counter are unchanged.
REQ-012 A read with empty=0 and sub=3 SHALL pop the byte: rd_ptr increments, sub returns to 0, and the counter decrements.
REQ-013 A read with empty=1 SHALL be ignored; sub, pointers and counter are unchanged.
REQ-014 A simultaneous accepted write and pop SHALL leave the counter unchanged while both pointers advance.
REQ-015 A write into an empty FIFO SHALL make the byte readable on the next cycle; write-to-dout latency is 1 clock.
REQ-016 empty SHALL be 1 exactly when counter=0, and full SHALL be 1 exactly when counter=2^ABITS; both are decoded from registered state.
REQ-017 The read-side sequencer SHALL be a 4-state FSM (SYM0, SYM1, SYM2, SYM3) encoded as sub.
  - Each accepted read moves SYMn to SYMn+1.
  - SYM3 moves to SYM0 with a pop.
  - The FSM holds its state when there is no accepted read.

Reset
REQ-018 Asserting reset_n=0 SHALL immediately and asynchronously clear wr_ptr, rd_ptr, counter and sub to 0, giving empty=1, full=0 and dout=0.
REQ-019 Reset mid-operation SHALL discard all stored bytes and any partially consumed byte; memory contents need not be cleared.
REQ-020 The first accepted write SHALL be the first rising edge of clk with reset_n=1 and write=1.

Structure
REQ-021 A shared package SHALL hold the defaults ABITS, DBITS and WBITS, the derived constant SYMS_PER_WORD=WBITS/DBITS, and the symbol-index width.
REQ-022 Byte storage SHALL be a sub-module fifo_ram: synchronous write, asynchronous read, parameterised by ABITS and WBITS.
REQ-023 Pointer, counter and FSM logic SHALL reside in byte_unpack_fifo.

Verification
REQ-024 Reset: drive reset_n=0 for 2 cycles -> empty=1, full=0 and dout=0 throughout.
REQ-025 Unpack: write 8'hE4, then read 4 times -> dout sequence 0,1,2,3, after which empty=1.
REQ-026 Fill: write 9 bytes 8'h00..8'h08 with no reads -> full=1 after the 8th write; the 9th byte is dropped; draining 32 reads returns only the 8'h00..8'h07 symbols.
REQ-027 Wrap plus concurrency: at occupancy 7, hold write and read for 12 cycles -> 3 pops (every 4th read) and 3 writes accepted, with pointers wrapping past 7 and no symbol lost.
REQ-028 Underflow: read with empty=1 -> no state change; a following write of 8'h1B yields dout=3,2,1,0.
REQ-029 Mid-reset: write 8'hFF, read 2 symbols, assert reset_n=0 -> empty=1; a following write of 8'h00 reads out symbol 0 from index 0.

Source files
------------

// File: rtl/byte_unpack_fifo_pkg.sv
// byte_unpack_fifo_pkg: shared widths and read-side symbol states
package byte_unpack_fifo_pkg;
    localparam int ABITS = 3;
    localparam int DBITS = 2;
    localparam int WBITS = 8;
    localparam int SYMS_PER_WORD = WBITS / DBITS;
    localparam int SUB_BITS = $clog2(SYMS_PER_WORD);
    typedef enum logic [SUB_BITS-1:0] {SYM0, SYM1, SYM2, SYM3} sym_e;
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: byte storage with synchronous write and asynchronous read
module fifo_ram #(
    parameter int ABITS = 3,
    parameter int WBITS = 8
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [ABITS-1:0] waddr_i,
    input  logic [WBITS-1:0] wdata_i,
    input  logic [ABITS-1:0] raddr_i,
    output logic [WBITS-1:0] rdata_o
);
    logic [WBITS-1:0] mem_q [2**ABITS];

    always_ff @(posedge clk)
        if (we_i) mem_q[waddr_i] <= wdata_i;

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/byte_unpack_fifo.sv
// byte_unpack_fifo: byte-wide FIFO that drains as LSB-first symbols,
// first-word-fall-through on dout
module byte_unpack_fifo #(
    parameter int ABITS = byte_unpack_fifo_pkg::ABITS,
    parameter int DBITS = byte_unpack_fifo_pkg::DBITS,
    parameter int WBITS = byte_unpack_fifo_pkg::WBITS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             write,
    input  logic             read,
    input  logic [WBITS-1:0] din,
    output logic [DBITS-1:0] dout,
    output logic             empty,
    output logic             full
);
    import byte_unpack_fifo_pkg::*;

    logic [ABITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ABITS:0]   cnt_q, cnt_d;
    sym_e             sub_q, sub_d;
    logic [WBITS-1:0] head;
    logic             wr_ok, rd_ok, pop;

    fifo_ram #(.ABITS(ABITS), .WBITS(WBITS)) u_ram (
        .clk     (clk),
        .we_i    (wr_ok),
        .waddr_i (wr_ptr_q),
        .wdata_i (din),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    assign empty = cnt_q == '0;
    assign full  = cnt_q == (ABITS+1)'(2**ABITS);
    assign dout  = empty ? '0 : head[sub_q*DBITS +: DBITS];

    always_comb begin
        wr_ok    = write & ~full;
        rd_ok    = read & ~empty;
        // the head byte only leaves once its last symbol is consumed
        pop      = rd_ok & (sub_q == SYM3);
        sub_d    = rd_ok ? (pop ? SYM0 : sym_e'(sub_q + SUB_BITS'(1))) : sub_q;
        wr_ptr_d = wr_ptr_q + ABITS'(wr_ok);
        rd_ptr_d = rd_ptr_q + ABITS'(pop);
        cnt_d    = cnt_q + (ABITS+1)'(wr_ok) - (ABITS+1)'(pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            sub_q    <= SYM0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            sub_q    <= sub_d;
        end
    end
endmodule

// File: tb/tb_byte_unpack_fifo.sv
// tb_byte_unpack_fifo: scoreboard bench; symbols queued on accepted writes, compared on accepted reads
module tb_byte_unpack_fifo;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic [7:0] din = '0;
    logic [1:0] dout;
    logic       empty, full;

    int errs = 0;
    int checks = 0;
    int n_wr = 0;
    int n_pop = 0;
    logic [1:0] sq[$];

    byte_unpack_fifo dut (
        .clk     (clk),
        .reset_n (reset_n),
        .write   (write),
        .read    (read),
        .din     (din),
        .dout    (dout),
        .empty   (empty),
        .full    (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one cycle from a negedge to the next; the model decides acceptance
    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        logic exp_e, exp_f, acc_w, acc_r;
        write = w;
        read  = r;
        din   = d;
        #1;
        exp_e = sq.size() == 0;
        exp_f = (sq.size() + 3) / 4 == 8;
        chk("empty", 32'(empty), 32'(exp_e));
        chk("full", 32'(full), 32'(exp_f));
        chk("dout", 32'(dout), exp_e ? 32'd0 : 32'(sq[0]));
        acc_w = w && !exp_f;
        acc_r = r && !exp_e;
        @(posedge clk);
        if (acc_r) begin
            if (sq.size() % 4 == 1) n_pop++;
            void'(sq.pop_front());
        end
        if (acc_w) begin
            n_wr++;
            for (int i = 0; i < 4; i++) sq.push_back(d[2*i +: 2]);
        end
        @(negedge clk);
        write = 1'b0;
        read  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sq.size() > 0; i++) cyc(1'b0, 1'b1, 8'h00);
        chk("drained", 32'(sq.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_empty", 32'(empty), 32'd1);
            chk("rst_full", 32'(full), 32'd0);
            chk("rst_dout", 32'(dout), 32'd0);
        end
        reset_n = 1'b1;
        // unpack ordering
        cyc(1'b1, 1'b0, 8'hE4);
        chk("e4_sym0", 32'(dout), 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'h00);
        chk("e4_empty", 32'(empty), 32'd1);
        // fill past capacity
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, 1'b0, 8'(i));
            if (i == 7) chk("full8", 32'(full), 32'd1);
        end
        chk("fill_q", 32'(sq.size()), 32'd32);
        drain();
        // wrap with concurrent write and read at occupancy 7
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'($urandom_range(0, 255)));
        n_wr  = 0;
        n_pop = 0;
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 8'hA0 + 8'(i));
        chk("wrap_writes", 32'(n_wr), 32'd3);
        chk("wrap_pops", 32'(n_pop), 32'd3);
        drain();
        // underflow then reversed pattern
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b0, 8'h1B);
        chk("1b_sym0", 32'(dout), 32'd3);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'h00);
        // reset in the middle of a byte
        cyc(1'b1, 1'b0, 8'hFF);
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b1, 8'h00);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_dout", 32'(dout), 32'd0);
        sq.delete();
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1'b1, 1'b0, 8'h00);
        chk("post_rst_sym", 32'(dout), 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'h00);
        chk("post_rst_empty", 32'(empty), 32'd1);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
